// File: rtl/port_lock_arbiter_if.sv
// port_lock_arbiter_if: request/release and grant/status bundle for one arbitrated output port
interface port_lock_arbiter_if #(
  parameter int NUM_REQ = 4
);
  localparam int IDW = $clog2(NUM_REQ);
  logic [NUM_REQ-1:0] req;
  logic [NUM_REQ-1:0] rel;
  logic [NUM_REQ-1:0] grant;
  logic [IDW-1:0] grant_id;
  logic busy;
  logic proto_err;
  logic timeout;
  modport master (
    output req, rel,
    input  grant, grant_id, busy, proto_err, timeout
  );
  modport slave (
    input  req, rel,
    output grant, grant_id, busy, proto_err, timeout
  );
endinterface

// File: rtl/port_lock_arbiter.sv
// port_lock_arbiter: round-robin arbiter locking one output port to a requester until release; PORT_TIMEOUT_EN adds a forced release after MAX_HOLD cycles
module port_lock_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int MAX_HOLD = 64
) (
  input logic clk,
  input logic rst,
  port_lock_arbiter_if.slave bus
);
  localparam int IDW = $clog2(NUM_REQ);
  typedef enum logic {IDLE, LOCKED} state_t;
  state_t state;
  logic [IDW-1:0] ptr;
  logic [IDW-1:0] win;
  logic [IDW-1:0] nxt;
  logic [IDW:0] s;
  logic rel_c;
  logic to_hit;
  // first asserted request scanning upward from ptr with wrap; downward loop lets the nearest index win
  always_comb begin
    win = '0;
    s = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      s = {1'b0, ptr} + (IDW+1)'(i);
      s = s >= (IDW+1)'(NUM_REQ) ? s - (IDW+1)'(NUM_REQ) : s;
      win = bus.req[s[IDW-1:0]] ? s[IDW-1:0] : win;
    end
  end
  assign nxt = bus.grant_id == IDW'(NUM_REQ - 1) ? '0 : bus.grant_id + 1'b1;
  assign rel_c = bus.rel[bus.grant_id] | ~bus.req[bus.grant_id];
`ifdef PORT_TIMEOUT_EN
  localparam int CW = $clog2(MAX_HOLD);
  logic [CW-1:0] cnt;
  assign to_hit = cnt == CW'(MAX_HOLD - 1);
`else
  assign to_hit = 1'b0;
  assign bus.timeout = 1'b0;
`endif
  // ownership FSM with registered outputs; pointer advances only on release
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      bus.grant <= '0;
      bus.grant_id <= '0;
      bus.busy <= 1'b0;
      bus.proto_err <= 1'b0;
      ptr <= '0;
`ifdef PORT_TIMEOUT_EN
      cnt <= '0;
      bus.timeout <= 1'b0;
`endif
    end else if (state == IDLE) begin
      bus.proto_err <= |bus.rel;
`ifdef PORT_TIMEOUT_EN
      cnt <= '0;
      bus.timeout <= 1'b0;
`endif
      if (|bus.req) begin
        state <= LOCKED;
        bus.grant <= NUM_REQ'(1) << win;
        bus.grant_id <= win;
        bus.busy <= 1'b1;
      end
    end else begin
      bus.proto_err <= |(bus.rel & ~bus.grant);
`ifdef PORT_TIMEOUT_EN
      cnt <= cnt + 1'b1;
      bus.timeout <= to_hit & ~rel_c;
`endif
      if (rel_c | to_hit) begin
        state <= IDLE;
        bus.grant <= '0;
        bus.busy <= 1'b0;
        ptr <= nxt;
      end
    end
  end
endmodule

// File: tb/tb_port_lock_arbiter.sv
// tb_port_lock_arbiter: scoreboard bench for port_lock_arbiter with NUM_REQ=4, MAX_HOLD=8
module tb_port_lock_arbiter;
  localparam int N = 4;
  localparam int MH = 8;
`ifdef PORT_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif
  typedef struct {
    logic [3:0] g;
    logic [1:0] id;
    logic idv;
    logic b;
    logic pe;
    logic to;
  } exp_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int n_chk = 0;
  int n_pass = 0;
  exp_t q[$];
  bit m_busy = 1'b0;
  int m_owner = 0;
  int m_ptr = 0;
  int m_cnt = 0;
  int ord[5] = '{0, 1, 2, 3, 0};
  port_lock_arbiter_if #(.NUM_REQ(N)) bus ();
  port_lock_arbiter #(.NUM_REQ(N), .MAX_HOLD(MH)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_chk++;
    if (got === want) n_pass++;
    else $display("FAIL %s got=%0h want=%0h at %0t", tag, got, want, $time);
  endtask
  task automatic step(input logic r, input logic [3:0] rq, input logic [3:0] rl);
    exp_t e;
    bit rc;
    bit th;
    e = '{g: 4'b0, id: 2'b0, idv: 1'b0, b: 1'b0, pe: 1'b0, to: 1'b0};
    rst = r;
    bus.req = rq;
    bus.rel = rl;
    if (r) begin
      m_busy = 1'b0;
      m_owner = 0;
      m_ptr = 0;
      m_cnt = 0;
      e.idv = 1'b1;
    end else if (!m_busy) begin
      e.pe = |rl;
      for (int k = 0; k < N; k++)
        if (!m_busy && rq[(m_ptr + k) % N]) begin
          m_busy = 1'b1;
          m_owner = (m_ptr + k) % N;
          m_cnt = 0;
        end
    end else begin
      e.pe = (rl & ~(4'b1 << m_owner)) != 4'b0;
      rc = rl[m_owner] || !rq[m_owner];
      th = TO_EN && m_cnt == MH - 1;
      if (rc || th) begin
        m_busy = 1'b0;
        m_ptr = (m_owner + 1) % N;
        e.to = th && !rc;
      end else m_cnt++;
    end
    e.b = m_busy;
    e.g = m_busy ? 4'b1 << m_owner : 4'b0;
    if (m_busy) begin
      e.id = 2'(m_owner);
      e.idv = 1'b1;
    end
    q.push_back(e);
    @(posedge clk);
    #1;
    e = q.pop_front();
    chk("grant", 32'(bus.grant), 32'(e.g));
    chk("busy", 32'(bus.busy), 32'(e.b));
    chk("proto_err", 32'(bus.proto_err), 32'(e.pe));
    chk("timeout", 32'(bus.timeout), 32'(e.to));
    if (e.idv) chk("grant_id", 32'(bus.grant_id), 32'(e.id));
  endtask
  initial begin
    bus.req = '0;
    bus.rel = '0;
    step(1'b1, 4'b0000, 4'b0000);
    step(1'b1, 4'b0000, 4'b0000);
    for (int i = 0; i < 5; i++) step(1'b0, 4'b0000, 4'b0000);
    step(1'b0, 4'b1010, 4'b0000);
    chk("t2_first_grant", 32'(bus.grant), 32'h2);
    step(1'b0, 4'b1010, 4'b0000);
    step(1'b0, 4'b1010, 4'b0010);
    chk("t2_release", 32'(bus.busy), 32'h0);
    step(1'b0, 4'b1010, 4'b0000);
    chk("t2_ptr_grant", 32'(bus.grant), 32'h8);
    step(1'b0, 4'b1010, 4'b1000);
    step(1'b0, 4'b0000, 4'b0000);
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 4'b1111, 4'b0000);
      chk("t3_order", 32'(bus.grant_id), 32'(ord[i]));
      step(1'b0, 4'b1111, 4'b0000);
      step(1'b0, 4'b1111, 4'(4'b1 << m_owner));
      chk("t3_bubble", 32'(bus.busy), 32'h0);
    end
    step(1'b0, 4'b0000, 4'b0000);
    step(1'b0, 4'b0100, 4'b0000);
    chk("t4_owner2", 32'(bus.grant), 32'h4);
    step(1'b0, 4'b0100, 4'b0001);
    chk("t4_perr", 32'(bus.proto_err), 32'h1);
    step(1'b0, 4'b0100, 4'b0000);
    chk("t4_perr_pulse", 32'(bus.proto_err), 32'h0);
    step(1'b0, 4'b0000, 4'b0000);
    chk("t4_abandon", 32'(bus.grant), 32'h0);
    step(1'b0, 4'b0010, 4'b0000);
    chk("t5_owner1", 32'(bus.grant), 32'h2);
    step(1'b1, 4'b0010, 4'b0000);
    step(1'b0, 4'b0011, 4'b0000);
    chk("t5_after_rst", 32'(bus.grant), 32'h1);
    step(1'b0, 4'b0011, 4'b0001);
    step(1'b0, 4'b1000, 4'b0100);
    step(1'b0, 4'b1000, 4'b1000);
    step(1'b1, 4'b0000, 4'b0000);
    step(1'b0, 4'b0101, 4'b0000);
    chk("t6_owner0", 32'(bus.grant), 32'h1);
    for (int i = 0; i < 110; i++) step(1'b0, 4'b0101, 4'b0000);
    step(1'b0, 4'b0000, 4'b0000);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
